// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl
//
// Control sequencer for an N-iteration restoring shift-subtract divider. The
// datapath (dividend/remainder/quotient registers and subtractor) lives
// outside this block; this FSM issues one strobe per step, owns the
// iteration counter, reports divide-by-zero and runs the start/done/ack
// handshake with the requester.
//
// Step sequence per division:
//   LOAD -> { SHIFT -> SUB -> TEST } x N -> DONE
//   LOAD -> ERR                             (divisor == 0)
// DONE/ERR hold until ack, then return to IDLE.
//
// Parameters:
//   N   number of quotient bits / iterations (2..15)
//   CW  iteration counter width, 2**CW > N
//
// Ports:
//   clk          system clock, all state on the rising edge
//   clr          synchronous active-high reset, overrides every input
//   start        request a division (sampled in IDLE only)
//   div_by_zero  datapath flag, divisor == 0 (sampled in LOAD only)
//   rem_neg      sign of the trial remainder (sampled in TEST only)
//   ack          requester consumed the result (sampled in DONE/ERR only)
//   busy         high in LOAD, SHIFT, SUB, TEST
//   ld_regs      load operands, clear quotient/remainder
//   shift_en     shift remainder:dividend left by one
//   sub_en       latch remainder - divisor as the trial remainder
//   restore_en   write the pre-subtract remainder back
//   q_we         shift q_bit into the quotient LSB
//   q_bit        quotient bit, meaningful while q_we = 1
//   iter_cnt     completed iteration count
//   done         result or error available, held until ack
//   err          divide-by-zero, valid while done = 1
// -----------------------------------------------------------------------------
module div_seq_ctrl #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          div_by_zero,
  input  logic          rem_neg,
  input  logic          ack,
  output logic          busy,
  output logic          ld_regs,
  output logic          shift_en,
  output logic          sub_en,
  output logic          restore_en,
  output logic          q_we,
  output logic          q_bit,
  output logic [CW-1:0] iter_cnt,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_SUB   = 3'd3,
    S_TEST  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t state, state_nxt;

  // The counter value seen in TEST is the count before this iteration's
  // increment, so the last iteration is the one that reads N-1.
  logic last_iter;
  assign last_iter = (iter_cnt == CW'(N - 1));

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Cleared on LOAD rather than on entry to IDLE, so the final count stays
  // readable after the requester acknowledges.
  always_ff @(posedge clk) begin
    if (clr)                  iter_cnt <= '0;
    else if (state == S_LOAD) iter_cnt <= '0;
    else if (state == S_TEST) iter_cnt <= iter_cnt + CW'(1);
  end

  always_comb begin
    // NOTE: every output and the next state get a default before the case,
    // so no path through this block can leave a value unassigned (latch).
    state_nxt  = state;
    busy       = 1'b0;
    ld_regs    = 1'b0;
    shift_en   = 1'b0;
    sub_en     = 1'b0;
    restore_en = 1'b0;
    q_we       = 1'b0;
    q_bit      = 1'b0;
    done       = 1'b0;
    err        = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy      = 1'b1;
        ld_regs   = 1'b1;
        state_nxt = div_by_zero ? S_ERR : S_SHIFT;
      end
      S_SHIFT: begin
        busy      = 1'b1;
        shift_en  = 1'b1;
        state_nxt = S_SUB;
      end
      S_SUB: begin
        busy      = 1'b1;
        sub_en    = 1'b1;
        state_nxt = S_TEST;
      end
      S_TEST: begin
        // A negative trial remainder means the divisor did not fit: record
        // a 0 and put the old remainder back; otherwise keep it and record 1.
        busy       = 1'b1;
        q_we       = 1'b1;
        q_bit      = ~rem_neg;
        restore_en = rem_neg;
        state_nxt  = last_iter ? S_DONE : S_SHIFT;
      end
      S_DONE: begin
        done = 1'b1;
        if (ack) state_nxt = S_IDLE;
      end
      S_ERR: begin
        done = 1'b1;
        err  = 1'b1;
        if (ack) state_nxt = S_IDLE;
      end
      default: begin
        // Unused encoding: fall back to IDLE on the next clock.
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_seq_ctrl
//
// Scoreboard bench for div_seq_ctrl. A behavioural divider datapath reacts to
// the DUT strobes and returns rem_neg. Stimulus pushes the expected LOAD
// cycle, quotient-bit stream (from a/b) and a completion record (cycle, err,
// count, quotient, remainder, done length) into queues; a monitor pops and
// compares whenever the DUT presents ld_regs, q_we or a rising done.
// -----------------------------------------------------------------------------
module tb_div_seq_ctrl;

  localparam int N   = 8;
  localparam int CW  = 4;
  localparam int LAT = 3 * N + 2;   // start cycle -> first done cycle

  logic          clk = 1'b0;
  logic          clr, start, div_by_zero, rem_neg, ack;
  logic          busy, ld_regs, shift_en, sub_en, restore_en, q_we, q_bit;
  logic [CW-1:0] iter_cnt;
  logic          done, err;

  div_seq_ctrl #(.N(N), .CW(CW)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .div_by_zero (div_by_zero),
    .rem_neg     (rem_neg),
    .ack         (ack),
    .busy        (busy),
    .ld_regs     (ld_regs),
    .shift_en    (shift_en),
    .sub_en      (sub_en),
    .restore_en  (restore_en),
    .q_we        (q_we),
    .q_bit       (q_bit),
    .iter_cnt    (iter_cnt),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    int cycle;
    bit err;
    int iter;
    int quo;
    int rem;
    int shifts;
    int hold;
  } done_rec_t;

  int        ld_exp[$];
  bit        q_exp[$];
  done_rec_t done_exp[$];

  // ------------------------------------------------------ behavioural datapath
  logic [N-1:0] a_in, b_in;
  logic [N:0]   m_rem, m_saved;
  logic [N-1:0] m_dvd, m_dvs, m_q;

  initial begin
    rem_neg = 1'b0;
    m_rem = '0; m_saved = '0; m_dvd = '0; m_dvs = '0; m_q = '0;
    forever begin
      @(negedge clk);
      if (ld_regs === 1'b1) begin
        m_rem = '0; m_dvd = a_in; m_dvs = b_in; m_q = '0;
      end
      if (shift_en === 1'b1) begin
        m_rem = {m_rem[N-1:0], m_dvd[N-1]};
        m_dvd = {m_dvd[N-2:0], 1'b0};
      end
      if (sub_en === 1'b1) begin
        m_saved = m_rem;
        m_rem   = m_rem - {1'b0, m_dvs};
        rem_neg = m_rem[N];
      end
      if (restore_en === 1'b1) m_rem = m_saved;
      if (q_we === 1'b1)       m_q   = {m_q[N-2:0], q_bit};
    end
  end

  // ------------------------------------------------------------------ monitor
  done_rec_t cur;
  int        done_len = 0;
  bit        in_done  = 1'b0;
  int        n_shift  = 0;
  int        n_sub    = 0;
  bit        e_bit;

  initial forever begin
    @(negedge clk);
    if (ld_regs | shift_en | sub_en)
      check("strobe_onehot", $countones({ld_regs, shift_en, sub_en}), 1);
    if (restore_en && !q_we)
      check("restore_without_qwe", restore_en, q_we);

    if (ld_regs) begin
      check("ld_expected", ld_exp.size() > 0, 1);
      if (ld_exp.size() > 0) check("ld_cycle", cyc, ld_exp.pop_front());
      check("busy_in_load", busy, 1);
      n_shift = 0;
      n_sub   = 0;
    end
    if (shift_en) n_shift++;
    if (sub_en)   n_sub++;

    if (q_we) begin
      check("q_expected", q_exp.size() > 0, 1);
      if (q_exp.size() > 0) begin
        e_bit = q_exp.pop_front();
        check("q_bit", q_bit, e_bit);
        check("restore_en", restore_en, !e_bit);
      end
    end

    if (done && !in_done) begin
      in_done  = 1'b1;
      done_len = 0;
      check("done_expected", done_exp.size() > 0, 1);
      if (done_exp.size() > 0) begin
        cur = done_exp.pop_front();
        check("done_cycle", cyc, cur.cycle);
        check("done_err", err, cur.err);
        check("done_iter_cnt", iter_cnt, cur.iter);
        check("done_busy", busy, 0);
        check("shift_pulses", n_shift, cur.shifts);
        check("sub_pulses", n_sub, cur.shifts);
        if (!cur.err) begin
          check("quotient", m_q, cur.quo);
          check("remainder", m_rem, cur.rem);
        end
      end else begin
        cur.hold = 0;
      end
    end
    if (done) done_len++;
    else if (in_done) begin
      check("done_length", done_len, cur.hold);
      in_done = 1'b0;
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present start in the current (IDLE) cycle and queue every expectation.
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input int hold);
    done_rec_t r;
    int ai, bi, c;
    ai = int'(a);
    bi = int'(b);
    c  = cyc;
    a_in = a;
    b_in = b;
    div_by_zero = (bi == 0);
    start = 1'b1;
    ld_exp.push_back(c + 1);
    if (bi != 0)
      for (int i = N - 1; i >= 0; i--) q_exp.push_back(bit'((ai / bi) >> i));
    r.cycle  = c + ((bi == 0) ? 2 : LAT);
    r.err    = (bi == 0);
    r.iter   = (bi == 0) ? 0 : N;
    r.quo    = (bi == 0) ? 0 : ai / bi;
    r.rem    = (bi == 0) ? 0 : ai % bi;
    r.shifts = (bi == 0) ? 0 : N;
    r.hold   = hold;
    done_exp.push_back(r);
  endtask

  // noise bit0: start pulse in SHIFT of iteration 1
  // noise bit1: ack pulse in TEST of iteration 1
  // noise bit2: start raised together with ack in DONE
  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                         input int ack_delay, input logic [2:0] noise);
    int d;
    launch(a, b, ack_delay + 1);
    d = ((b == 0) ? 2 : LAT) + ack_delay;
    for (int rel = 1; rel <= d; rel++) begin
      tick();
      start = (noise[0] && rel == 5) || (noise[2] && rel == d);
      ack   = (noise[1] && rel == 7) || (rel == d);
    end
    tick();
    start = 1'b0;
    ack   = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_iter_cnt", iter_cnt, (b == 0) ? 0 : N);
  endtask

  task automatic back_to_back();
    int c0;
    c0  = cyc;
    ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      while (cyc < c0 + (LAT + 1) * i) tick();
      launch(N'($urandom_range(0, 255)), N'($urandom_range(1, 255)), 1);
    end
    while (cyc < c0 + 3 * (LAT + 1)) tick();
    start = 1'b0;
    ack   = 1'b0;
    tick();
    check("b2b_idle_busy", busy, 0);
  endtask

  task automatic clr_mid_op();
    int c;
    c = cyc;
    launch(N'(200), N'(9), 1);
    tick();
    start = 1'b0;
    while (cyc < c + 12) tick();
    check("iter_cnt_in_sub3", iter_cnt, 3);
    check("busy_in_sub3", busy, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    q_exp.delete();
    done_exp.delete();
    check("clr_busy", busy, 0);
    check("clr_iter_cnt", iter_cnt, 0);
    check("clr_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      check("post_clr_strobes", {ld_regs, shift_en, sub_en, q_we, restore_en}, 0);
      tick();
    end
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; ack = 1'b0; div_by_zero = 1'b0;
    a_in = '0; b_in = 8'd1;
    tick();
    tick();
    clr = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_ld_regs", ld_regs, 0);
    check("rst_shift_en", shift_en, 0);
    check("rst_sub_en", sub_en, 0);
    check("rst_restore_en", restore_en, 0);
    check("rst_q_we", q_we, 0);
    check("rst_q_bit", q_bit, 0);
    check("rst_iter_cnt", iter_cnt, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    tick();

    run_div(8'd100, 8'd7, 0, 3'b000);   // nominal, quotient 14
    run_div(8'd100, 8'd0, 5, 3'b000);   // divide-by-zero, done held 5 cycles
    run_div(8'd255, 8'd1, 0, 3'b000);   // all-ones quotient
    run_div(N'($urandom_range(0, 255)), N'($urandom_range(1, 255)), 0, 3'b011);
    run_div(N'($urandom_range(0, 255)), N'($urandom_range(1, 255)), 0, 3'b100);
    tick();
    back_to_back();
    clr_mid_op();
    for (int i = 0; i < 5; i++)
      run_div(N'($urandom_range(0, 255)), N'($urandom_range(1, 255)),
              int'($urandom_range(0, 3)), 3'b000);
    tick();
    tick();

    check("ld_queue_empty", ld_exp.size(), 0);
    check("q_queue_empty", q_exp.size(), 0);
    check("done_queue_empty", done_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Moore FSM that sequences an N-iteration restoring shift-subtract divider datapath (dividend/remainder/quotient registers, subtractor).
- Issues one-hot control strobes per step and owns the iteration counter.
- Flags divide-by-zero.
- Start/done/ack handshake with the requesting logic.

Parameters:
- N, 8, number of quotient bits / iterations; legal range 2..15.
- CW, 4, iteration counter width; must satisfy 2^CW > N.

Ports:
- clk  input  1  system clock, all state on posedge.
- clr  input  1  synchronous active-high reset.
- start  input  1  request a new division; sampled only in IDLE.
- div_by_zero  input  1  datapath flag, divisor == 0; sampled only in LOAD.
- rem_neg  input  1  sign of the trial remainder after subtraction; sampled only in TEST.
- ack  input  1  requester has consumed the result; sampled only in DONE/ERR.
- busy  output  1  high in LOAD, SHIFT, SUB and TEST.
- ld_regs  output  1  load operands into the datapath and clear quotient/remainder.
- shift_en  output  1  shift the remainder:dividend pair left by 1.
- sub_en  output  1  latch remainder minus divisor into the trial remainder.
- restore_en  output  1  write the pre-subtract remainder back.
- q_we  output  1  shift q_bit into the quotient LSB.
- q_bit  output  1  quotient bit; meaningful only while q_we = 1.
- iter_cnt  output  CW  completed iteration count.
- done  output  1  result or error available; held until ack.
- err  output  1  divide-by-zero; valid while done = 1.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - clr is synchronous, active-high, and has priority over all inputs. This includes mid-operation: the next state is IDLE regardless of current state.
- Reset values: state = IDLE, iter_cnt = 0, and all outputs 0.
- Output decoding:
  - All outputs are decoded from registered state only (Moore); none depends combinationally on an input.
  - Exception: restore_en and q_bit in TEST are a function of rem_neg.
- States and transitions:
  - IDLE: if start = 1, go to LOAD; else stay.
  - LOAD: ld_regs = 1, iter_cnt <= 0. If div_by_zero = 1, go to ERR; else go to SHIFT.
  - SHIFT: shift_en = 1; go to SUB.
  - SUB: sub_en = 1; go to TEST.
  - TEST: q_we = 1, q_bit = ~rem_neg, restore_en = rem_neg, iter_cnt <= iter_cnt + 1.
    - If iter_cnt == N-1 (value before increment), go to DONE.
    - Otherwise go to SHIFT.
  - DONE: done = 1, err = 0. If ack = 1, go to IDLE; else stay.
  - ERR: done = 1, err = 1. If ack = 1, go to IDLE; else stay.
- Strobes: at most one of ld_regs, shift_en and sub_en is high in any cycle.
- Latency (cycle 0 = the IDLE cycle in which start is sampled high):
  - LOAD in cycle 1.
  - Iteration k (0-based) occupies cycles 2+3k through 4+3k.
  - done first high in cycle 3N+2; cycle 26 for N = 8.
  - Error path: err and done first high in cycle 2.
- iter_cnt:
  - Reads N throughout DONE.
  - Holds its value through the following IDLE; it is cleared only by LOAD or clr.
- Boundary conditions:
  - start while busy, or while in DONE/ERR: ignored, no queuing.
  - ack outside DONE/ERR: ignored.
  - ack and start both high in DONE: go to IDLE only; start is not accepted that cycle and must still be high in IDLE to launch.
  - ack held continuously high: DONE lasts exactly 1 cycle.
  - div_by_zero outside LOAD: ignored.
  - rem_neg outside TEST: ignored.
  - Illegal or unreachable state encodings: recover to IDLE on the next clock.

Test Plan:
- Reset: assert clr for 2 cycles from power-up, then check all outputs 0 and iter_cnt = 0. Next, run a divide, assert clr in iteration 3 SUB, and check that state returns to IDLE the next cycle with busy = 0, iter_cnt = 0 and no further strobes.
- Nominal 100/7, N = 8, with a bench datapath model:
  - start at cycle 0, then ld_regs at cycle 1.
  - q_we pulses at cycles 4, 7, …, 25 with q_bit sequence 0,0,0,0,1,1,1,0 (quotient 14).
  - restore_en high exactly on the 0 bits.
  - done high at cycle 26 with err = 0 and iter_cnt = 8.
- Divide-by-zero: start with div_by_zero = 1 at LOAD; check done = err = 1 at cycle 2 and no shift_en or sub_en pulses. Hold done for 5 cycles without ack, then ack, then IDLE next cycle.
- Handshake:
  - start pulsed during SHIFT: ignored.
  - ack pulsed during TEST: ignored.
  - ack and start together in DONE: return to IDLE and no LOAD.
  - start held high into IDLE: LOAD the next cycle.
- Back-to-back operation: keep ack and start tied high and check that a LOAD occurs every 3N+3 = 27 cycles, with done high for exactly 1 cycle each time.
- All-ones quotient, 255/1: rem_neg = 0 always; check q_bit = 1 on all 8 q_we pulses and restore_en never asserted.
